speaker_control: RTL and testbench
==================================

// Module: speaker_control
// PURPOSE
//   Consumer end of the 16-bit stereo sample interface driven by the tone/buzzer
//   generators. Samples au_left/au_right once per audio frame and serialises them
//   MSB-first in I2S format to the on-board stereo DAC. Generates the DAC clocks
//   (MCLK, LRCK, SCK) from the system clock.
//   Sits between the note/audio generators and the DAC pins.
// PARAMETERS
//   MCLK_LOG2   2    MCLK = clk / 2^MCLK_LOG2 (25 MHz at 100 MHz clk)
//   SCK_LOG2    4    SCK  = clk / 2^SCK_LOG2  (6.25 MHz)
//   FRAME_LOG2  10   clk cycles per LRCK period = 2^FRAME_LOG2 (97.66 kHz fs)
//   Legal set: 2^(FRAME_LOG2-1-SCK_LOG2) >= 17 bit slots per channel.
//   SCK_LOG2 > MCLK_LOG2.
//   Defaults are used below; slots per channel NSLOT = 32.
// PORTS
//   clk          in   1   system clock, 100 MHz
//   rst          in   1   asynchronous, active-high reset
//   en           in   1   synchronous enable; 0 = stop and restart the frame
//   au_left      in   16  left sample, two's complement
//   au_right     in   16  right sample, two's complement
//   audio_mclk   out  1   DAC master clock
//   audio_lrck   out  1   word select; 0 = left, 1 = right
//   audio_sck    out  1   serial bit clock
//   audio_sdin   out  1   serial data, registered
//   sample_tick  out  1   1-clk pulse: new sample pair just latched
// BEHAVIOUR
//   - cnt: 10-bit free-running frame counter; +1 per clk while en=1; wraps 1023->0.
//   - Clock outputs, all derived from cnt with no extra logic:
//     audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[9].
//   - Slot and channel: slot = cnt[8:4] (0..31), ch = cnt[9].
//   - Sample latch: on the edge where cnt==1023 && en:
//     hold_l <= au_left, hold_r <= au_right.
//     Both channels are captured on the same edge, so there is no L/R tearing.
//     Input changes at other times are ignored until the next latch.
//   - sample_tick: registered; 1 for exactly the one cycle in which cnt==0 after a
//     latch; 0 otherwise and while en=0.
//   - Serial data: on each edge where cnt[3:0]==15 (sck falling):
//     audio_sdin <= bit(ns, nch), where {nch,ns} = cnt[9:4]+1 mod 64.
//     bit(s,c) = 0 for s==0 (I2S one-SCK delay).
//     bit(s,c) = hold_c[16-s] for s in 1..16 (MSB at slot 1).
//     bit(s,c) = 0 for s in 17..31.
//     audio_sdin is otherwise held, so data is stable across every sck rising edge.
//   - Wrap 1023->0: the latch and the slot-0 zero coincide, so the new holds are
//     first used at slot 1 of the left channel.
//   - en=0: cnt <= 0 and audio_sdin <= 0 at the next edge; hold regs retained;
//     no latch and no tick. Re-assertion starts a fresh frame at cnt=0
//     (left channel, slot 0).
//   - rst=1 (async, at any time incl. mid-frame): cnt, hold_l, hold_r, audio_sdin
//     and sample_tick go to 0 immediately. All outputs are therefore 0.
//     The first frame after reset transmits silence (zeros).
//   - Latency: sample presented at latch -> MSB on sdin 16 clk later
//     -> last left bit 272 clk after the latch.
// TESTING
//   1 Reset/clocks: rst pulse -> all outputs 0.
//     After release, en=1: mclk period 4, sck 16, lrck 1024 clk; lrck=1 for cnt 512..1023.
//   2 Data: hold au_left=16'h8005, au_right=16'h7FFF for 3 frames.
//     Frame 2, sampled on sck rising: left slots 1..16 = 1000000000000101,
//     right slots 1..16 = 0111111111111111, all other slots 0.
//   3 Mid-frame change: au_left 16'h1234 -> 16'hABCD at cnt=300.
//     Current frame still sends 16'h1234; the next frame sends 16'hABCD.
//   4 Tick: count sample_tick over 10 frames -> exactly 10, each at cnt==0.
//     No tick while en=0.
//   5 Enable: drop en at cnt=700 for 50 clk -> cnt=0 and sdin=0 next clk, clocks low.
//     On re-enable, lrck=0 and slot 0 begins; holds unchanged.
//   6 Reset mid right channel (cnt=800, async, not clk-aligned).
//     -> outputs 0 within the same cycle.
//     Post-release, the first frame sdin is all 0; the second frame carries inputs.

Source files
------------

// File: rtl/speaker_control.sv
// Purpose : I2S stereo serialiser for the on-board DAC; makes MCLK/SCK/LRCK from clk.
// Latency : sample pair latched at frame wrap; MSB on audio_sdin 16 clk later.
// Backpr. : none; inputs are sampled once per frame, changes in between are ignored.
//
// Ports
//   clk          system clock (100 MHz)
//   rst          asynchronous active-high reset; clears counter, holds, sdin, tick
//   en           synchronous enable; low stops the frame and restarts it at slot 0
//   au_left      left sample, two's complement, sampled once per frame
//   au_right     right sample, two's complement, sampled on the same edge as left
//   audio_mclk   DAC master clock, clk / 2^MCLK_LOG2
//   audio_lrck   word select, 0 = left channel, 1 = right channel
//   audio_sck    serial bit clock, clk / 2^SCK_LOG2
//   audio_sdin   serial data, registered, changes on sck falling edge only
//   sample_tick  one-clk pulse in the cycle after a new sample pair was latched
//
// Legal parameters: 2^(FRAME_LOG2-1-SCK_LOG2) >= 17 slots per channel and
// SCK_LOG2 > MCLK_LOG2 >= 1.

module speaker_control #(
  parameter int MCLK_LOG2  = 2,
  parameter int SCK_LOG2   = 4,
  parameter int FRAME_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] au_left,
  input  logic [15:0] au_right,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  // Slot index within one channel, and slot+channel position within a frame.
  localparam int SLOT_W = FRAME_LOG2 - 1 - SCK_LOG2;
  localparam int POS_W  = FRAME_LOG2 - SCK_LOG2;

  localparam logic [FRAME_LOG2-1:0] CNT_ONE  = 1;
  localparam logic [POS_W-1:0]      POS_ONE  = 1;
  localparam logic [SLOT_W-1:0]     SLOT_MSB = 16;  // slot carrying bit 0 (LSB)

  logic [FRAME_LOG2-1:0] cnt;
  logic [15:0]           hold_l;
  logic [15:0]           hold_r;

  logic                  frame_end;
  logic                  sck_fall;
  logic [POS_W-1:0]      next_pos;
  logic                  next_ch;
  logic [SLOT_W-1:0]     next_slot;
  logic [15:0]           next_word;
  logic                  next_bit;

  // All DAC clocks are plain counter taps, so they stay phase-locked to the
  // data and to each other without any extra state.
  assign audio_mclk = cnt[MCLK_LOG2-1];
  assign audio_sck  = cnt[SCK_LOG2-1];
  assign audio_lrck = cnt[FRAME_LOG2-1];

  assign frame_end = &cnt;
  // Last clk of an SCK period: the edge that ends it is the sck falling edge.
  assign sck_fall  = &cnt[SCK_LOG2-1:0];

  // sdin is loaded one slot ahead, so decode the slot that is about to begin.
  // At frame wrap this rolls to left slot 0, which is always the I2S delay zero.
  assign next_pos  = cnt[FRAME_LOG2-1:SCK_LOG2] + POS_ONE;
  assign next_ch   = next_pos[POS_W-1];
  assign next_slot = next_pos[SLOT_W-1:0];
  assign next_word = next_ch ? hold_r : hold_l;

  // Slot 1 carries the MSB, slot 16 the LSB; slot 0 and slots past 16 are zero.
  always_comb begin
    next_bit = 1'b0;
    if (next_slot != '0 && next_slot <= SLOT_MSB) begin
      next_bit = next_word[4'(SLOT_MSB - next_slot)];
    end
  end

  // Frame counter: free-running while enabled, parked at 0 otherwise so a
  // re-enable always starts on the left channel, slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Both channels are captured on the same edge so a stereo pair can never be
  // split across frames. The wrap edge also loads the slot-0 zero into sdin,
  // so the new pair is first used at left slot 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (en && frame_end) begin
      hold_l <= au_left;
      hold_r <= au_right;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= en && frame_end;
    end
  end

  // sdin only moves on sck falling edges, keeping it stable around every
  // rising edge where the DAC samples it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_sdin <= 1'b0;
    end else if (!en) begin
      audio_sdin <= 1'b0;
    end else if (sck_fall) begin
      audio_sdin <= next_bit;
    end
  end

endmodule

// File: tb/tb_speaker_control.sv
// Bench for speaker_control: per-cycle comparison against a frame-position model,
// table-driven sample words, and hand sequences for enable/reset corner cases.
module tb_speaker_control;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] au_left;
  logic [15:0] au_right;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        sample_tick;

  speaker_control dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .au_left     (au_left),
    .au_right    (au_right),
    .audio_mclk  (audio_mclk),
    .audio_lrck  (audio_lrck),
    .audio_sck   (audio_sck),
    .audio_sdin  (audio_sdin),
    .sample_tick (sample_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: position in frame plus the sample pair in effect.
  int          m_cnt;
  logic [15:0] m_hl;
  logic [15:0] m_hr;
  logic        m_tick;

  logic [63:0] cap;            // sdin seen at each slot's sck rising edge
  int          dut_ticks;
  int          misplaced_ticks;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected serial bit at frame position m_cnt: slot s of a channel carries
  // bit 16-s of that channel's sample for s = 1..16, zero everywhere else.
  function automatic logic model_bit();
    logic [9:0]  c;
    logic [15:0] h;
    int          s;
    c = m_cnt[9:0];
    s = int'(c[8:4]);
    h = c[9] ? m_hr : m_hl;
    if (s >= 1 && s <= 16) return h[16 - s];
    return 1'b0;
  endfunction

  // Advance one clk (called at a falling edge with inputs already driven),
  // then compare every output against the model.
  task automatic cycle();
    logic       nt;
    logic [9:0] c;
    nt = en && (m_cnt == 1023);
    if (!en) begin
      m_cnt = 0;
    end else begin
      if (m_cnt == 1023) begin
        m_hl = au_left;
        m_hr = au_right;
      end
      m_cnt = (m_cnt + 1) % 1024;
    end
    m_tick = nt;
    @(posedge clk);
    @(negedge clk);
    c = m_cnt[9:0];
    check($sformatf("outputs@cnt%0d", m_cnt),
          {59'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick},
          {59'd0, c[1], c[3], c[9], model_bit(), m_tick});
    if (c[3:0] == 4'd8) cap[c[9:4]] = audio_sdin;
    if (sample_tick) begin
      dut_ticks++;
      if (c != 10'd0) misplaced_ticks++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Decode a captured frame: left word in slots 1..16, right in 33..48.
  task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
    logic [15:0] wl;
    logic [15:0] wr;
    for (int s = 1; s <= 16; s++) begin
      wl[16 - s] = cap[s];
      wr[16 - s] = cap[32 + s];
    end
    check({tag, "_left"}, {48'd0, wl}, {48'd0, el});
    check({tag, "_right"}, {48'd0, wr}, {48'd0, er});
    check({tag, "_other_slots"}, cap & ~64'h0001_FFFE_0001_FFFE, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int m_rise, s_rise, lr_hi, first_hi;
    logic pm, ps;
    int off_left;

    vecs[0] = '{16'h8005, 16'h7FFF, 16'h8005, 16'h7FFF};
    vecs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[2] = '{16'h8000, 16'h0001, 16'h8000, 16'h0001};
    vecs[3] = '{16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};
    vecs[4] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
    vecs[5] = '{16'hFFFF, 16'h8001, 16'hFFFF, 16'h8001};

    dut_ticks = 0;
    misplaced_ticks = 0;

    // 1: reset and clock generation
    rst = 1'b1;
    en = 1'b0;
    au_left = 16'h0000;
    au_right = 16'h0000;
    #2;
    check("reset_outputs",
          {59'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    m_hl = 16'h0000;
    m_hr = 16'h0000;
    m_tick = 1'b0;
    #1;
    check("release_outputs",
          {59'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick}, 64'd0);
    @(negedge clk);
    en = 1'b1;
    au_left = 16'h4321;
    au_right = 16'h8765;
    m_rise = 0;
    s_rise = 0;
    lr_hi = 0;
    first_hi = -1;
    pm = 1'b0;
    ps = 1'b0;
    cap = '1;
    for (int i = 0; i < 1024; i++) begin
      cycle();
      if (audio_mclk && !pm) m_rise++;
      if (audio_sck && !ps) s_rise++;
      if (audio_lrck) begin
        lr_hi++;
        if (first_hi < 0) first_hi = m_cnt;
      end
      pm = audio_mclk;
      ps = audio_sck;
    end
    check("mclk_rises_per_frame", 64'(m_rise), 64'd256);
    check("sck_rises_per_frame", 64'(s_rise), 64'd64);
    check("lrck_high_cycles", 64'(lr_hi), 64'd512);
    check("lrck_first_high_cnt", 64'(first_hi), 64'd512);
    check_frame("first_frame_silence", 16'h0000, 16'h0000);
    cap = '1;
    run(1024);
    check_frame("second_frame_data", 16'h4321, 16'h8765);

    // 2: table of sample pairs, each held for a frame then captured
    for (int v = 0; v < 6; v++) begin
      au_left = vecs[v].l;
      au_right = vecs[v].r;
      run(1024);
      cap = '1;
      run(1024);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_l, vecs[v].exp_r);
    end

    // 3: mid-frame input change is deferred to the next frame
    au_left = 16'h1234;
    au_right = 16'h00FF;
    run(1024);
    cap = '1;
    run(300);
    au_left = 16'hABCD;
    run(724);
    check_frame("midchange_current", 16'h1234, 16'h00FF);
    cap = '1;
    run(1024);
    check_frame("midchange_next", 16'hABCD, 16'h00FF);

    // 4: exactly one tick per frame, at cnt 0; none while disabled
    dut_ticks = 0;
    misplaced_ticks = 0;
    run(10240);
    check("ticks_in_10_frames", 64'(dut_ticks), 64'd10);
    check("ticks_off_cnt0", 64'(misplaced_ticks), 64'd0);
    en = 1'b0;
    dut_ticks = 0;
    run(100);
    check("ticks_while_disabled", 64'(dut_ticks), 64'd0);
    en = 1'b1;

    // 5: enable drop mid-frame; holds survive and the frame restarts
    au_left = 16'h0F0F;
    au_right = 16'hF0F0;
    run(1024);
    run(700);
    en = 1'b0;
    cycle();
    check("disable_clocks_sdin",
          {60'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin}, 64'd0);
    au_left = 16'h1111;
    au_right = 16'h2222;
    run(49);
    en = 1'b1;
    cap = '1;
    cycle();
    check("reenable_lrck_left", {63'd0, audio_lrck}, 64'd0);
    run(1023);
    check_frame("reenable_old_holds", 16'h0F0F, 16'hF0F0);

    // 6: asynchronous reset in the right channel
    au_left = 16'hC3A5;
    au_right = 16'h5A3C;
    run(800);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {59'd0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick}, 64'd0);
    m_cnt = 0;
    m_hl = 16'h0000;
    m_hr = 16'h0000;
    m_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cap = '1;
    run(1024);
    check_frame("post_reset_silence", 16'h0000, 16'h0000);
    cap = '1;
    run(1024);
    check_frame("post_reset_data", 16'hC3A5, 16'h5A3C);

    // Randomised inputs and enable drops, checked every cycle by the model
    off_left = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom % 64 == 0) au_left = 16'($urandom);
      if ($urandom % 64 == 0) au_right = 16'($urandom);
      if (en && ($urandom % 1500 == 0)) begin
        en = 1'b0;
        off_left = int'($urandom_range(1, 40));
      end else if (!en) begin
        off_left--;
        if (off_left <= 0) en = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
